// File: rtl/program_loader.sv
// Writable program memory with byte-stream loader.
// A host streams DEPTH instruction bytes plus a checksum byte; the CPU is
// held in reset until a load with a matching checksum completes. The CPU
// fetch port reads the RAM combinationally, like the ROM it replaces.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              LOAD_START,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Order,
    output logic              CPU_CLR,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    // Count is one bit wider than the address so the last word index is
    // reachable without the counter aliasing back to zero.
    localparam logic [ADDR_W:0] C_LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t              r_state;
    logic [ADDR_W:0]     r_count;
    logic [DATA_W-1:0]   r_sum;
    logic                r_cpu_clr;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_ready;
    logic                w_xfer;

    // A restart pulse blocks acceptance so a coincident byte is not consumed.
    assign w_ready  = ((r_state == S_LOAD) || (r_state == S_CHECK)) && !LOAD_START;
    assign w_xfer   = w_ready && IN_VALID;

    assign IN_READY = w_ready;
    assign CPU_CLR  = r_cpu_clr;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ERR      = r_err;
    assign Order    = r_mem[Address];

    // Load sequencer: counts data bytes, accumulates checksum, verifies it.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_sum     <= '0;
            r_cpu_clr <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else if (LOAD_START) begin
            r_state   <= S_LOAD;
            r_count   <= '0;
            r_sum     <= '0;
            r_cpu_clr <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_xfer) begin
                        r_sum   <= r_sum + IN_DATA;
                        r_count <= r_count + (ADDR_W+1)'(1);
                        if (r_count == C_LAST) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        r_busy <= 1'b0;
                        if (IN_DATA == r_sum) begin
                            r_state   <= S_RUN;
                            r_cpu_clr <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Program RAM: cleared on reset, written only by data bytes in LOAD.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_xfer && (r_state == S_LOAD)) begin
            r_mem[r_count[ADDR_W-1:0]] <= IN_DATA;
        end
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writable program memory and its byte-stream loader. It replaces the fixed instruction ROM as the responder to the CPU's instruction fetch.
- A host streams DEPTH instruction bytes plus one checksum byte over a valid/ready interface. The block stores them in a 16x8 RAM and holds the CPU in reset until a load with a good checksum completes.
- On the fetch side the CPU drives Address and reads Order combinationally, exactly as it did from the ROM.

Parameters:
ADDR_W, 4, fetch address width
DATA_W, 8, instruction/stream byte width
DEPTH, 16, number of program words (2**ADDR_W)

Ports:
CLK  input  1  system clock, all state updates on rising edge
CLR  input  1  synchronous, active-high reset
LOAD_START  input  1  single-cycle pulse; begins (or restarts) a program load
IN_DATA  input  DATA_W  stream byte from host
IN_VALID  input  1  IN_DATA valid
IN_READY  output  1  loader accepts the byte this cycle
Address  input  ADDR_W  CPU fetch address (PC)
Order  output  DATA_W  instruction at Address, combinational read
CPU_CLR  output  1  reset to CPU; high unless a verified program is in RAM
BUSY  output  1  high in LOAD or CHECK
DONE  output  1  high in RUN
ERR  output  1  high in ERROR

Behaviour:
- Transfer: occurs on a rising edge when IN_VALID && IN_READY. IN_READY = (state==LOAD || state==CHECK) && !LOAD_START.
- Reset (CLR=1 at an edge): state<=IDLE, count<=0, sum<=0. All RAM words are cleared to 0x00.
- Outputs while in reset and IDLE: IN_READY=0, CPU_CLR=1, BUSY=0, DONE=0, ERR=0, Order=0x00.
- Reset mid-load behaves identically; partially written data is discarded.
- States: IDLE, LOAD, CHECK, RUN, ERROR. Outputs decode from the state register only, apart from the IN_READY gating above.
- IDLE: LOAD_START -> LOAD with count<=0, sum<=0.
- LOAD: on each transfer, mem[count]<=IN_DATA, sum<=sum+IN_DATA (mod 2**DATA_W, wraps), count<=count+1.
  - The transfer with count==DEPTH-1 moves to CHECK.
  - With no transfer the state holds; IN_VALID gaps of any length are legal.
- CHECK: one transfer is accepted as the checksum byte and is not written to RAM.
  - IN_DATA==sum -> RUN; otherwise -> ERROR.
- RUN: CPU_CLR=0, DONE=1. CPU_CLR falls on the edge that accepts a matching checksum, so the CPU leaves reset the next cycle with PC=0.
- ERROR: CPU_CLR=1, ERR=1. RAM keeps the bytes written during the failed load.
- LOAD_START in any non-reset state (LOAD, CHECK, RUN, ERROR) -> LOAD with count<=0, sum<=0.
  - IN_READY is low that cycle, so a coincident IN_VALID byte is not consumed; the host must re-present it.
  - RAM is not cleared; it is overwritten as bytes arrive.
- CLR has priority over LOAD_START.
- Fetch read: Order = mem[Address], asynchronous, valid in every state.
  - A write at an edge is visible on Order from the following cycle.
  - The read port has no side effects.
- count is ADDR_W+1 bits internally, or equivalent, so DEPTH-1 terminates cleanly. Address is always in range (0..DEPTH-1).

Test Plan:
1. Reset: assert CLR for 2 cycles with IN_VALID=1 -> IN_READY=0, CPU_CLR=1, DONE=0, ERR=0, BUSY=0, Order=0x00 for Address 0..15.
2. Good load: LOAD_START, then bytes 0x00..0x0F, then checksum 0x78 -> BUSY for 17 transfers, then DONE=1 and CPU_CLR=0 the cycle after the checksum. Address=5 gives Order=0x05; Address=15 gives 0x0F.
3. Bad checksum: same 16 bytes, checksum 0x77 -> ERR=1, CPU_CLR=1, DONE=0. Address=3 still reads 0x03.
4. Wraparound and backpressure: 16 bytes of 0xFF with random 0-5 cycle IN_VALID gaps, checksum 0xF0 -> RUN. Every word reads 0xFF and exactly 17 transfers occur.
5. Restart: after 7 bytes, pulse LOAD_START while IN_VALID=1 with 0xAA -> IN_READY=0 that cycle and 0xAA is not stored. Then load 0x10..0x1F with checksum 0x78 -> RUN; Address 0 reads 0x10.
6. Reset mid-load: CLR after 9 bytes -> IDLE next cycle, every word reads 0x00, CPU_CLR=1. Bytes presented afterwards are ignored until LOAD_START.
